// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the exception sequencer: MIPS ExcCode values, the
// exception vector and the sequencer state encoding.
package exc_sequencer_pkg;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcSys  = 5'd8;
  localparam logic [4:0] ExcBp   = 5'd9;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;

  localparam logic [31:0] ExcVector = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitBus = 2'd1,
    StCommit  = 2'd2
  } exc_state_e;

endpackage

// File: rtl/exc_prio.sv
// Combinational exception resolution for the MEM-stage instruction.
// Inputs : instruction valid, interrupt sources/masks, per-cause flags, faulting addresses.
// Outputs: exc_o (some exception or interrupt taken), excode_o of the winner,
//          badva_o / badva_we_o for address-error causes.
module exc_prio
  import exc_sequencer_pkg::*;
(
  input  logic        valid_i,
  input  logic [5:0]  ext_int_i,
  input  logic [1:0]  sw_ip_i,
  input  logic [7:0]  im_i,
  input  logic        ie_i,
  input  logic        exl_i,
  input  logic        inst_adel_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        sys_i,
  input  logic        bp_i,
  input  logic        data_adel_i,
  input  logic        data_ades_i,
  input  logic [31:0] inst_badva_i,
  input  logic [31:0] data_badva_i,
  output logic        exc_o,
  output logic [4:0]  excode_o,
  output logic [31:0] badva_o,
  output logic        badva_we_o
);

  logic int_pending;

  assign int_pending = valid_i & ie_i & ~exl_i & (|({ext_int_i, sw_ip_i} & im_i));

  // Priority chain, highest first.
  always_comb begin
    exc_o      = 1'b1;
    excode_o   = ExcInt;
    badva_o    = 32'h0;
    badva_we_o = 1'b0;
    if (int_pending) begin
      excode_o = ExcInt;
    end else if (inst_adel_i) begin
      excode_o   = ExcAdel;
      badva_o    = inst_badva_i;
      badva_we_o = 1'b1;
    end else if (ri_i) begin
      excode_o = ExcRi;
    end else if (ov_i) begin
      excode_o = ExcOv;
    end else if (sys_i) begin
      excode_o = ExcSys;
    end else if (bp_i) begin
      excode_o = ExcBp;
    end else if (data_adel_i) begin
      excode_o   = ExcAdel;
      badva_o    = data_badva_i;
      badva_we_o = 1'b1;
    end else if (data_ades_i) begin
      excode_o   = ExcAdes;
      badva_o    = data_badva_i;
      badva_we_o = 1'b1;
    end else begin
      exc_o = 1'b0;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception / ERET sequencer at the MEM commit point.
// Detects an event, stalls the pipe, waits for any outstanding data-bus
// transaction, then spends one COMMIT cycle flushing, redirecting fetch and
// writing CP0 (exception) or clearing EXL (ERET).
// Inputs : MEM-stage instruction info and flags, interrupt lines, CP0 state,
//          data_req_pending.
// Outputs: stall, flush, redirect_valid/pc, CP0 write strobes and values.
module exc_sequencer
  import exc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        mem_inst_adel,
  input  logic        mem_ri,
  input  logic        mem_ov,
  input  logic        mem_sys,
  input  logic        mem_bp,
  input  logic        mem_data_adel,
  input  logic        mem_data_ades,
  input  logic [31:0] mem_inst_badva,
  input  logic [31:0] mem_data_badva,
  input  logic        mem_eret,
  input  logic [5:0]  ext_int,
  input  logic [1:0]  cp0_sw_ip,
  input  logic [7:0]  cp0_im,
  input  logic        cp0_ie,
  input  logic        cp0_exl,
  input  logic [31:0] cp0_epc,
  input  logic        data_req_pending,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        cp0_exc_we,
  output logic        cp0_eret,
  output logic [4:0]  cp0_excode,
  output logic [31:0] cp0_epc_wr,
  output logic        cp0_bd,
  output logic [31:0] cp0_badva,
  output logic        cp0_badva_we
);

  exc_state_e  state_q, state_d;
  logic [4:0]  excode_q, excode_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [31:0] badva_q, badva_d;
  logic        badva_we_q, badva_we_d;
  logic        is_exc_q, is_exc_d;
  logic [31:0] target_q, target_d;

  logic        prio_exc;
  logic [4:0]  prio_excode;
  logic [31:0] prio_badva;
  logic        prio_badva_we;
  logic        evt;
  logic        capture;

  exc_prio u_exc_prio (
    .valid_i      (mem_valid),
    .ext_int_i    (ext_int),
    .sw_ip_i      (cp0_sw_ip),
    .im_i         (cp0_im),
    .ie_i         (cp0_ie),
    .exl_i        (cp0_exl),
    .inst_adel_i  (mem_inst_adel),
    .ri_i         (mem_ri),
    .ov_i         (mem_ov),
    .sys_i        (mem_sys),
    .bp_i         (mem_bp),
    .data_adel_i  (mem_data_adel),
    .data_ades_i  (mem_data_ades),
    .inst_badva_i (mem_inst_badva),
    .data_badva_i (mem_data_badva),
    .exc_o        (prio_exc),
    .excode_o     (prio_excode),
    .badva_o      (prio_badva),
    .badva_we_o   (prio_badva_we)
  );

  // Gated by resetn so an event during reset cannot raise stall.
  assign evt = resetn & mem_valid & (prio_exc | mem_eret);

  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    cp0_exc_we     = 1'b0;
    cp0_eret       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (evt) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = data_req_pending ? StWaitBus : StCommit;
        end
      end
      StWaitBus: begin
        stall = 1'b1;
        if (!data_req_pending) state_d = StCommit;
      end
      StCommit: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        cp0_exc_we     = is_exc_q;
        cp0_eret       = ~is_exc_q;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Exceptions outrank ERET on the same instruction.
  always_comb begin
    excode_d   = excode_q;
    epc_d      = epc_q;
    bd_d       = bd_q;
    badva_d    = badva_q;
    badva_we_d = badva_we_q;
    is_exc_d   = is_exc_q;
    target_d   = target_q;
    if (capture) begin
      excode_d   = prio_excode;
      epc_d      = mem_bd ? (mem_pc - 32'd4) : mem_pc;
      bd_d       = mem_bd;
      badva_d    = prio_badva;
      badva_we_d = prio_badva_we;
      is_exc_d   = prio_exc;
      target_d   = prio_exc ? ExcVector : cp0_epc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      excode_q   <= 5'd0;
      epc_q      <= 32'h0;
      bd_q       <= 1'b0;
      badva_q    <= 32'h0;
      badva_we_q <= 1'b0;
      is_exc_q   <= 1'b0;
      target_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      excode_q   <= excode_d;
      epc_q      <= epc_d;
      bd_q       <= bd_d;
      badva_q    <= badva_d;
      badva_we_q <= badva_we_d;
      is_exc_q   <= is_exc_d;
      target_q   <= target_d;
    end
  end

  assign redirect_pc  = target_q;
  assign cp0_excode   = excode_q;
  assign cp0_epc_wr   = epc_q;
  assign cp0_bd       = bd_q;
  assign cp0_badva    = badva_q;
  assign cp0_badva_we = (state_q == StCommit) & badva_we_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_bd, mem_eret, data_req_pending;
  logic [31:0] mem_pc, mem_inst_badva, mem_data_badva, cp0_epc;
  logic        mem_inst_adel, mem_ri, mem_ov, mem_sys, mem_bp, mem_data_adel, mem_data_ades;
  logic [5:0]  ext_int;
  logic [1:0]  cp0_sw_ip;
  logic [7:0]  cp0_im;
  logic        cp0_ie, cp0_exl;
  logic        stall, flush, redirect_valid, cp0_exc_we, cp0_eret, cp0_bd, cp0_badva_we;
  logic [31:0] redirect_pc, cp0_epc_wr, cp0_badva;
  logic [4:0]  cp0_excode;

  int n_checks = 0;
  int n_bad    = 0;

  exc_sequencer dut (
    .clk              (clk),
    .resetn           (resetn),
    .mem_valid        (mem_valid),
    .mem_pc           (mem_pc),
    .mem_bd           (mem_bd),
    .mem_inst_adel    (mem_inst_adel),
    .mem_ri           (mem_ri),
    .mem_ov           (mem_ov),
    .mem_sys          (mem_sys),
    .mem_bp           (mem_bp),
    .mem_data_adel    (mem_data_adel),
    .mem_data_ades    (mem_data_ades),
    .mem_inst_badva   (mem_inst_badva),
    .mem_data_badva   (mem_data_badva),
    .mem_eret         (mem_eret),
    .ext_int          (ext_int),
    .cp0_sw_ip        (cp0_sw_ip),
    .cp0_im           (cp0_im),
    .cp0_ie           (cp0_ie),
    .cp0_exl          (cp0_exl),
    .cp0_epc          (cp0_epc),
    .data_req_pending (data_req_pending),
    .stall            (stall),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .cp0_exc_we       (cp0_exc_we),
    .cp0_eret         (cp0_eret),
    .cp0_excode       (cp0_excode),
    .cp0_epc_wr       (cp0_epc_wr),
    .cp0_bd           (cp0_bd),
    .cp0_badva        (cp0_badva),
    .cp0_badva_we     (cp0_badva_we)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one in-flight transaction, committed once the bus is free.
  typedef struct {
    bit          is_exc;
    logic [4:0]  code;
    logic [31:0] epc;
    bit          bd;
    logic [31:0] badva;
    bit          badva_we;
    logic [31:0] target;
  } txn_t;

  txn_t m_txn;
  bit   m_busy   = 0;  // captured, waiting for the bus
  bit   m_commit = 0;  // commit happens in the current cycle

  // Checks outputs for the current cycle at the falling edge, then advances
  // the model to the next cycle. Callers change inputs after it returns.
  task automatic cycle();
    bit          flg[8];
    logic [4:0]  codes[8];
    int          first;
    bit          intr, ev;
    txn_t        t;
    codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
    @(negedge clk);
    intr = mem_valid && cp0_ie && !cp0_exl && (({ext_int, cp0_sw_ip} & cp0_im) != 8'h0);
    flg = '{intr, mem_inst_adel, mem_ri, mem_ov, mem_sys, mem_bp, mem_data_adel, mem_data_ades};
    first = -1;
    for (int i = 0; i < 8; i++) if (flg[i] && first < 0) first = i;
    ev = mem_valid && (first >= 0 || mem_eret);

    if (!resetn) begin
      check_eq("rst_stall", stall, 0);
      check_eq("rst_flush", flush, 0);
      check_eq("rst_redir", redirect_valid, 0);
      check_eq("rst_exc_we", cp0_exc_we, 0);
      check_eq("rst_eret", cp0_eret, 0);
      check_eq("rst_badva_we", cp0_badva_we, 0);
      check_eq("rst_excode", cp0_excode, 0);
      check_eq("rst_epc", cp0_epc_wr, 0);
      check_eq("rst_rpc", redirect_pc, 0);
      m_busy   = 0;
      m_commit = 0;
    end else if (m_commit) begin
      check_eq("c_stall", stall, 0);
      check_eq("c_flush", flush, 1);
      check_eq("c_redir", redirect_valid, 1);
      check_eq("c_rpc", redirect_pc, m_txn.target);
      check_eq("c_exc_we", cp0_exc_we, m_txn.is_exc);
      check_eq("c_eret", cp0_eret, !m_txn.is_exc);
      if (m_txn.is_exc) begin
        check_eq("c_excode", cp0_excode, m_txn.code);
        check_eq("c_epc", cp0_epc_wr, m_txn.epc);
        check_eq("c_bd", cp0_bd, m_txn.bd);
        check_eq("c_badva_we", cp0_badva_we, m_txn.badva_we);
        if (m_txn.badva_we) check_eq("c_badva", cp0_badva, m_txn.badva);
      end
      m_commit = 0;
    end else if (m_busy) begin
      check_eq("w_stall", stall, 1);
      check_eq("w_flush", flush, 0);
      check_eq("w_exc_we", cp0_exc_we, 0);
      if (!data_req_pending) begin
        m_busy   = 0;
        m_commit = 1;
      end
    end else begin
      check_eq("i_stall", stall, ev);
      check_eq("i_flush", flush, 0);
      check_eq("i_redir", redirect_valid, 0);
      if (ev) begin
        t.is_exc   = (first >= 0);
        t.code     = (first >= 0) ? codes[first] : 5'd0;
        t.bd       = mem_bd;
        t.epc      = mem_bd ? mem_pc - 32'd4 : mem_pc;
        t.badva_we = (first == 1 || first == 6 || first == 7);
        t.badva    = (first == 1) ? mem_inst_badva : mem_data_badva;
        t.target   = t.is_exc ? 32'hBFC0_0380 : cp0_epc;
        m_txn      = t;
        if (data_req_pending) m_busy = 1;
        else m_commit = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    mem_valid = 0; mem_bd = 0; mem_eret = 0; data_req_pending = 0;
    mem_pc = 32'h0; mem_inst_badva = 32'h0; mem_data_badva = 32'h0; cp0_epc = 32'h0;
    mem_inst_adel = 0; mem_ri = 0; mem_ov = 0; mem_sys = 0; mem_bp = 0;
    mem_data_adel = 0; mem_data_ades = 0;
    ext_int = 6'h0; cp0_sw_ip = 2'h0; cp0_im = 8'h0; cp0_ie = 0; cp0_exl = 0;
  endtask

  task automatic drain();
    clear_in();
    repeat (3) cycle();
  endtask

  initial begin
    clear_in();
    resetn = 0;
    cycle();
    cycle();
    resetn = 1;
    cycle();

    // Overflow, bus idle: stall now, commit next cycle.
    mem_valid = 1; mem_ov = 1; mem_pc = 32'h8000_0100;
    cycle();
    check_eq("ov_flush", flush, 1);
    check_eq("ov_code", cp0_excode, 12);
    check_eq("ov_epc", cp0_epc_wr, 32'h8000_0100);
    check_eq("ov_rpc", redirect_pc, 32'hBFC0_0380);
    drain();

    // Data AdES in a delay slot.
    mem_valid = 1; mem_data_ades = 1; mem_bd = 1; mem_pc = 32'h8000_0204;
    mem_data_badva = 32'h8000_0003;
    cycle();
    check_eq("ades_code", cp0_excode, 5);
    check_eq("ades_epc", cp0_epc_wr, 32'h8000_0200);
    check_eq("ades_bd", cp0_bd, 1);
    check_eq("ades_badva", cp0_badva, 32'h8000_0003);
    check_eq("ades_bwe", cp0_badva_we, 1);
    drain();

    // Interrupt beats RI; with EXL set RI wins.
    mem_valid = 1; mem_ri = 1; ext_int = 6'h01; cp0_im = 8'h04; cp0_ie = 1; cp0_exl = 0;
    cycle();
    check_eq("int_code", cp0_excode, 0);
    drain();
    mem_valid = 1; mem_ri = 1; ext_int = 6'h01; cp0_im = 8'h04; cp0_ie = 1; cp0_exl = 1;
    cycle();
    check_eq("ri_code", cp0_excode, 10);
    drain();

    // Syscall with the bus busy for three cycles.
    mem_valid = 1; mem_sys = 1; data_req_pending = 1;
    cycle();
    mem_valid = 0; mem_sys = 0;
    cycle();
    cycle();
    data_req_pending = 0;
    cycle();
    check_eq("sys_commit", flush, 1);
    cycle();
    check_eq("sys_once", flush, 0);
    drain();

    // ERET alone, then ERET together with Bp.
    mem_valid = 1; mem_eret = 1; cp0_epc = 32'h8000_1000;
    cycle();
    check_eq("eret_strobe", cp0_eret, 1);
    check_eq("eret_exc_we", cp0_exc_we, 0);
    check_eq("eret_rpc", redirect_pc, 32'h8000_1000);
    drain();
    mem_valid = 1; mem_eret = 1; mem_bp = 1; cp0_epc = 32'h8000_1000;
    cycle();
    check_eq("bp_code", cp0_excode, 9);
    check_eq("bp_eret", cp0_eret, 0);
    drain();

    // Reset while waiting for the bus, with an event still asserted.
    mem_valid = 1; mem_ov = 1; data_req_pending = 1;
    cycle();
    resetn = 0;
    #1;
    check_eq("arst_stall", stall, 0);
    check_eq("arst_flush", flush, 0);
    check_eq("arst_redir", redirect_valid, 0);
    cycle();
    data_req_pending = 0;
    cycle();
    resetn = 1;
    clear_in();
    repeat (3) begin
      cycle();
      check_eq("arst_nocommit", flush, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      mem_valid        = ($urandom_range(0, 3) != 0);
      mem_pc           = $urandom & 32'hFFFF_FFFC;
      mem_bd           = $urandom_range(0, 1);
      mem_inst_adel    = ($urandom_range(0, 11) == 0);
      mem_ri           = ($urandom_range(0, 11) == 0);
      mem_ov           = ($urandom_range(0, 11) == 0);
      mem_sys          = ($urandom_range(0, 11) == 0);
      mem_bp           = ($urandom_range(0, 11) == 0);
      mem_data_adel    = ($urandom_range(0, 11) == 0);
      mem_data_ades    = ($urandom_range(0, 11) == 0);
      mem_eret         = ($urandom_range(0, 5) == 0);
      mem_inst_badva   = $urandom;
      mem_data_badva   = $urandom;
      ext_int          = 6'($urandom);
      cp0_sw_ip        = 2'($urandom);
      cp0_im           = 8'($urandom) & 8'($urandom);
      cp0_ie           = $urandom_range(0, 1);
      cp0_exl          = $urandom_range(0, 1);
      cp0_epc          = $urandom;
      data_req_pending = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
